ex_muldiv_ctrl: RTL and testbench

- Multi-cycle RV32M execution unit and sequencer alongside the single-cycle EX ALU.
- Accepts one MUL/DIV/REM operation from the EX stage and runs it iteratively.
- Stalls the pipeline while the operation is in flight.
- Delivers the result and write-back controls for one cycle when finished.
- Decode raises start_i only for opcode ARITH with funct7 = 0000001.

---
 rtl/ex_muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, pipeline stall while busy and a one-cycle write-back strobe.
module ex_muldiv_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [4:0]        wreg_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              wreg_en_o,
  output logic [4:0]        wreg_addr_o,
  output logic [DATA_W-1:0] wreg_data_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: start_i is a level held by the pipeline while stall_o=1; it is
  // accepted only in IDLE without flush_i. done_o pulses once per completed op.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [4:0]          waddr_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                sign_a_q, sign_b_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                special_q;
  logic [DATA_W-1:0]   special_res_q;

  logic                accept;
  logic                a_signed, b_signed, sign_a, sign_b;
  logic                div_zero, div_ovf, special;
  logic [DATA_W-1:0]   a_mag, b_mag, special_res;

  assign accept   = (state_q == S_IDLE) && start_i && !flush_i;
  assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign sign_a   = a_signed && rs1_data_i[DATA_W-1];
  assign sign_b   = b_signed && rs2_data_i[DATA_W-1];
  assign a_mag    = sign_a ? ({DATA_W{1'b0}} - rs1_data_i) : rs1_data_i;
  assign b_mag    = sign_b ? ({DATA_W{1'b0}} - rs2_data_i) : rs2_data_i;

  // Division corner cases bypass the iteration and carry their final value.
  assign div_zero = (rs2_data_i == '0);
  assign div_ovf  = !funct3_i[0] && (rs1_data_i == {1'b1, {(DATA_W-1){1'b0}}}) &&
                    (rs2_data_i == {DATA_W{1'b1}});
  assign special  = funct3_i[2] && (div_zero || div_ovf);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3_i[1] ? rs1_data_i : {DATA_W{1'b1}};
    else          special_res = funct3_i[1] ? '0 : {1'b1, {(DATA_W-1){1'b0}}};
  end

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? a_q : {DATA_W{1'b0}})};
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide step: upper half is the remainder, lower half shifts dividend out / quotient in.
  logic [DATA_W:0]     div_part, div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem;
  logic [2*DATA_W-1:0] div_next;
  assign div_part = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff = div_part - {1'b0, b_q};
  assign div_ge   = (div_part >= {1'b0, b_q});
  assign div_rem  = div_ge ? div_diff[DATA_W-1:0] : div_part[DATA_W-1:0];
  assign div_next = {div_rem, acc_q[DATA_W-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        stall_o = start_i && !flush_i;
        if (accept) begin
          if (special)          state_d = S_DONE;
          else if (funct3_i[2]) state_d = S_DIV;
          else                  state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        stall_o = !flush_i;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = !flush_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q      <= '0;
      waddr_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      special_q     <= 1'b0;
      special_res_q <= '0;
    end else if (accept) begin
      funct3_q      <= funct3_i;
      waddr_q       <= wreg_addr_i;
      a_q           <= a_mag;
      b_q           <= b_mag;
      sign_a_q      <= sign_a;
      sign_b_q      <= sign_b;
      cnt_q         <= {CNT_W{1'b1}};
      special_q     <= special;
      special_res_q <= special_res;
      // Multiply seeds the low half with B; divide seeds it with A.
      acc_q         <= {{DATA_W{1'b0}}, (funct3_i[2] ? a_mag : b_mag)};
    end else if (state_q == S_MUL) begin
      acc_q <= mul_next;
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == S_DIV) begin
      acc_q <= div_next;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Sign fix-up is applied only on the way out, from the latched magnitudes.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   mul_res, quo_fix, rem_fix, div_res, result;
  assign prod_fix = (sign_a_q ^ sign_b_q) ? ({(2*DATA_W){1'b0}} - acc_q) : acc_q;
  assign mul_res  = (funct3_q[1:0] == 2'b00) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? ({DATA_W{1'b0}} - acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
  assign rem_fix  = sign_a_q ? ({DATA_W{1'b0}} - acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];
  assign div_res  = funct3_q[1] ? rem_fix : quo_fix;
  assign result   = special_q ? special_res_q : (funct3_q[2] ? div_res : mul_res);

  assign wreg_addr_o = waddr_q;
  assign wreg_data_o = done_o ? result : '0;
  assign wreg_en_o   = done_o && (waddr_q != 5'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed and randomized bench for ex_muldiv_ctrl against an arithmetic RV32M model.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  wreg_addr_i;
  logic        flush_i;
  logic        stall_o, busy_o, done_o, wreg_en_o;
  logic [4:0]  wreg_addr_o;
  logic [31:0] wreg_data_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wreg_addr_i(wreg_addr_i),
    .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
    .wreg_en_o(wreg_en_o), .wreg_addr_o(wreg_addr_o), .wreg_data_o(wreg_data_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        p;
    int                 si;
    logic               ovf;
    sa  = 64'(signed'(a));
    sb  = 64'(signed'(b));
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        si = signed'(a) / signed'(b);
        return si;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        si = signed'(a) % signed'(b);
        return si;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Called shortly after a rising edge while the unit is idle: that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa);
    logic [31:0] exp;
    int          lat, cyc;
    logic        stall_ok;
    exp = ref_op(f, a, b);
    lat = ref_lat(f, a, b);
    start_i = 1'b1; funct3_i = f; rs1_data_i = a; rs2_data_i = b; wreg_addr_i = wa;
    #1;
    chk({tag, "_stall_c0"}, stall_o, 1'b1);
    cyc = 0;
    stall_ok = 1'b1;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      @(posedge clk); #1;
      if (done_o) cyc = c;
      else if (!stall_o || !busy_o) stall_ok = 1'b0;
    end
    chk({tag, "_done_cycle"}, cyc, lat);
    chk({tag, "_stall_busy"}, stall_ok, 1'b1);
    if (cyc != 0) begin
      chk({tag, "_data"}, wreg_data_o, exp);
      chk({tag, "_wen"}, wreg_en_o, (wa != 0));
      chk({tag, "_waddr"}, wreg_addr_o, wa);
      chk({tag, "_stall_done"}, stall_o, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, {busy_o, done_o, wreg_data_o}, '0);
    end
    start_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic        seen_done;
    rst = 1'b1; start_i = 0; funct3_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    wreg_addr_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {stall_o, busy_o, done_o, wreg_en_o, wreg_addr_o, wreg_data_o}, '0);
    rst = 1'b0;

    run_op("mul_neg",  3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10);
    run_op("divu",     3'b101, 32'd100, 32'd7, 5'd11);
    run_op("remu",     3'b111, 32'd100, 32'd7, 5'd12);
    run_op("divu_z",   3'b101, 32'h1234, 32'd0, 5'd13);
    run_op("remu_z",   3'b111, 32'h1234, 32'd0, 5'd14);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    run_op("mul_x0",   3'b000, 32'd9, 32'd9, 5'd0);

    // Flush mid-divide: instruction is squashed in cycle 10.
    start_i = 1; funct3_i = 3'b100; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; wreg_addr_i = 5'd3;
    seen_done = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (done_o) seen_done = 1'b1; end
    flush_i = 1; start_i = 0;
    #1;
    chk("flush_stall_drop", stall_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 0;
    chk("flush_idle", {busy_o, stall_o, done_o}, '0);
    repeat (30) begin @(posedge clk); #1; if (done_o) seen_done = 1'b1; end
    chk("flush_no_done", seen_done, 1'b0);

    // Reset mid-divide in cycle 20.
    start_i = 1; funct3_i = 3'b101; rs1_data_i = 32'd5000; rs2_data_i = 32'd9; wreg_addr_i = 5'd21;
    repeat (20) @(posedge clk);
    #1;
    rst = 1; start_i = 0;
    @(posedge clk); #1;
    chk("rst_mid_op", {stall_o, busy_o, done_o, wreg_en_o, wreg_addr_o, wreg_data_o}, '0);
    rst = 0;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 5'd2);

    // Flush together with start in IDLE is not accepted.
    start_i = 1; flush_i = 1; funct3_i = 3'b000; rs1_data_i = 5; rs2_data_i = 6; wreg_addr_i = 1;
    #1;
    chk("flush_start_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    start_i = 0; flush_i = 0;
    chk("flush_start_idle", busy_o, 1'b0);

    // Back-to-back: second op is driven in the IDLE cycle right after DONE.
    run_op("b2b_divu",  3'b101, 32'hDEAD_BEEF, 32'd1234, 5'd17);
    run_op("b2b_mulhu", 3'b011, 32'hCAFE_F00D, 32'h1234_5678, 5'd18);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op("rand", f, a, b, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
